// File: rtl/thejesvinii_axi.sv
// thejesvinii_axi: AXI4-Lite-style slave, 16 x 4-bit register file,
// last read data shown as a hex digit on a 7-segment display.
//
// Ports:
//   clk      i  system clock, rising edge
//   rst_n    i  synchronous reset, ACTIVE-HIGH despite the name
//   ena      i  tile enable (unused, block always runs)
//   ui_in    i  [3:0] address, [7:4] write data
//   uio_in   i  [0] arvalid [1] rready [2] awvalid [3] wvalid
//   uio_out  o  [4] arready [5] rvalid [6] awready [7] wready
//   uio_oe   o  constant 8'hF0
//   uo_out   o  [6:0] segments {g..a} of rdata, [7] dp = 0

module thejesvinii_axi (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       ena,
   input  logic [7:0] ui_in,
   input  logic [7:0] uio_in,
   output logic [7:0] uio_out,
   output logic [7:0] uio_oe,
   output logic [7:0] uo_out
);

   typedef enum logic {R_IDLE, R_DATA} rstate_e;

   rstate_e     rstate_q, rstate_d;
   logic [3:0]  mem_q [16];
   logic [3:0]  rdata_q, rdata_d;
   logic        arready_q, arready_d;
   logic        rvalid_q, rvalid_d;
   logic        wrdy_q, wrdy_d;
   logic [6:0]  seg;

   logic [3:0] addr;
   logic [3:0] wdata;
   logic       arvalid, rready, awvalid, wvalid;
   logic       wr_acc;
   logic       unused_ok;

   assign addr    = ui_in[3:0];
   assign wdata   = ui_in[7:4];
   assign arvalid = uio_in[0];
   assign rready  = uio_in[1];
   assign awvalid = uio_in[2];
   assign wvalid  = uio_in[3];

   assign unused_ok = &{1'b0, ena, uio_in[7:4]};

   // awready/wready share one register: they always pulse together,
   // and a pending pulse blocks acceptance of a back-to-back write.
   assign wr_acc = awvalid & wvalid & ~wrdy_q;
   assign wrdy_d = wr_acc;

   always_comb begin
      rstate_d  = rstate_q;
      rdata_d   = rdata_q;
      arready_d = 1'b0;
      rvalid_d  = rvalid_q;
      unique case (rstate_q)
         R_IDLE: begin
            if (arvalid) begin
               // mem_q is the pre-write value on a same-edge collision
               rdata_d   = mem_q[addr];
               arready_d = 1'b1;
               rvalid_d  = 1'b1;
               rstate_d  = R_DATA;
            end
         end
         R_DATA: begin
            if (rready) begin
               rvalid_d = 1'b0;
               rstate_d = R_IDLE;
            end
         end
         default: rstate_d = R_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst_n) begin
         rstate_q  <= R_IDLE;
         rdata_q   <= '0;
         arready_q <= 1'b0;
         rvalid_q  <= 1'b0;
         wrdy_q    <= 1'b0;
      end else begin
         rstate_q  <= rstate_d;
         rdata_q   <= rdata_d;
         arready_q <= arready_d;
         rvalid_q  <= rvalid_d;
         wrdy_q    <= wrdy_d;
      end
   end

   always_ff @(posedge clk) begin
      if (rst_n) begin
         for (int i = 0; i < 16; i++) begin
            mem_q[i] <= '0;
         end
      end else if (wr_acc) begin
         mem_q[addr] <= wdata;
      end
   end

   always_comb begin
      seg = 7'h3F;
      unique case (rdata_q)
         4'h0: seg = 7'h3F;
         4'h1: seg = 7'h06;
         4'h2: seg = 7'h5B;
         4'h3: seg = 7'h4F;
         4'h4: seg = 7'h66;
         4'h5: seg = 7'h6D;
         4'h6: seg = 7'h7D;
         4'h7: seg = 7'h07;
         4'h8: seg = 7'h7F;
         4'h9: seg = 7'h6F;
         4'hA: seg = 7'h77;
         4'hB: seg = 7'h7C;
         4'hC: seg = 7'h39;
         4'hD: seg = 7'h5E;
         4'hE: seg = 7'h79;
         4'hF: seg = 7'h71;
         default: seg = 7'h3F;
      endcase
   end

   assign uo_out  = {1'b0, seg};
   assign uio_out = {wrdy_q, wrdy_q, rvalid_q, arready_q, 4'b0000};
   assign uio_oe  = 8'hF0;

endmodule

// File: tb/tb_thejesvinii_axi.sv
// tb_thejesvinii_axi: directed test-plan sequences plus random traffic,
// every cycle compared with a transaction-level reference model.

module tb_thejesvinii_axi;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       ena;
   logic [7:0] ui_in;
   logic [7:0] uio_in;
   logic [7:0] uio_out;
   logic [7:0] uio_oe;
   logic [7:0] uo_out;

   thejesvinii_axi dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .ena     (ena),
      .ui_in   (ui_in),
      .uio_in  (uio_in),
      .uio_out (uio_out),
      .uio_oe  (uio_oe),
      .uo_out  (uo_out)
   );

   always #5 clk = ~clk;

   localparam logic [3:0] AR = 4'h1;
   localparam logic [3:0] RR = 4'h2;
   localparam logic [3:0] AW = 4'h4;
   localparam logic [3:0] WV = 4'h8;

   logic [7:0] seg_tab [16];

   int n_chk  = 0;
   int n_pass = 0;

   // reference model: register file, last read value, and
   // the handshake signals the master should currently see
   int  m_mem [16];
   int  m_rd;
   bit  m_ar, m_rv, m_wr;

   task automatic chk(input string tag, input logic [7:0] got,
                      input logic [7:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %02h expected %02h", tag, got, exp);
   endtask

   task automatic model_edge();
      bit racc, wacc;
      int a;
      a = int'(ui_in[3:0]);
      if (rst_n) begin
         foreach (m_mem[i]) m_mem[i] = 0;
         m_rd = 0; m_ar = 0; m_rv = 0; m_wr = 0;
         return;
      end
      // a read is outstanding exactly while rvalid is shown
      racc = uio_in[0] && !m_rv;
      wacc = uio_in[2] && uio_in[3] && !m_wr;
      m_ar = racc;
      if (racc) begin
         m_rd = m_mem[a];
         m_rv = 1;
      end else if (m_rv && uio_in[1]) begin
         m_rv = 0;
      end
      if (wacc) m_mem[a] = int'(ui_in[7:4]);
      m_wr = wacc;
   endtask

   task automatic cyc(input logic [7:0] ui, input logic [3:0] v,
                      input logic rst);
      ui_in  = ui;
      uio_in = {$urandom_range(0, 15), v};
      rst_n  = rst;
      @(posedge clk);
      model_edge();
      @(negedge clk);
      chk("uio_out", uio_out, {m_wr, m_wr, m_rv, m_ar, 4'h0});
      chk("uo_out", uo_out, seg_tab[m_rd]);
      chk("uio_oe", uio_oe, 8'hF0);
   endtask

   initial begin
      seg_tab = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07,
                  8'h7F, 8'h6F, 8'h77, 8'h7C, 8'h39, 8'h5E, 8'h79, 8'h71};
      ena = 1'b1; ui_in = '0; uio_in = '0; rst_n = 1'b1;
      foreach (m_mem[i]) m_mem[i] = 0;
      m_rd = 0; m_ar = 0; m_rv = 0; m_wr = 0;
      @(negedge clk);

      cyc(8'h00, 4'h0, 1'b1);
      cyc(8'h00, 4'h0, 1'b1);
      chk("rst_uio", uio_out, 8'h00);
      chk("rst_seg", uo_out, 8'h3F);
      cyc(8'h09, AR, 1'b0);
      chk("rst_rd", uo_out, 8'h3F);
      cyc(8'h00, RR, 1'b0);

      cyc(8'hA5, AW | WV, 1'b0);
      chk("wr_pulse", uio_out, 8'hC0);
      cyc(8'h00, 4'h0, 1'b0);
      chk("wr_done", uio_out, 8'h00);
      cyc(8'h05, AR, 1'b0);
      chk("rd5_seg", uo_out, 8'h77);
      chk("rd5_hs", uio_out, 8'h30);
      cyc(8'h05, 4'h0, 1'b0);
      chk("rv_hold", uio_out, 8'h20);
      cyc(8'h00, RR, 1'b0);
      chk("rv_drop", uio_out, 8'h00);

      for (int i = 0; i < 16; i++) begin
         cyc({4'(15 - i), 4'(i)}, AW | WV, 1'b0);
         cyc(8'h00, 4'h0, 1'b0);
      end
      for (int i = 0; i < 16; i++) begin
         cyc(8'(i), AR, 1'b0);
         chk("sweep", uo_out, seg_tab[15 - i]);
         cyc(8'h00, RR, 1'b0);
      end

      cyc(8'h02, AR, 1'b0);
      for (int k = 0; k < 10; k++) begin
         cyc(8'h07, AR, 1'b0);
         chk("bp_hs", uio_out, 8'h20);
         chk("bp_seg", uo_out, 8'h5E);
      end
      cyc(8'h00, RR, 1'b0);
      chk("bp_done", uio_out, 8'h00);

      for (int k = 0; k < 5; k++) begin
         cyc(8'h34, AW, 1'b0);
         chk("aw_only", uio_out, 8'h00);
      end
      for (int k = 0; k < 5; k++) begin
         cyc(8'h34, WV, 1'b0);
         chk("w_only", uio_out, 8'h00);
      end
      cyc(8'h04, AR, 1'b0);
      chk("partial", uo_out, 8'h7C);
      cyc(8'h00, RR, 1'b0);

      cyc(8'h23, AW | WV, 1'b0);
      cyc(8'h00, 4'h0, 1'b0);
      cyc(8'h73, AR | AW | WV, 1'b0);
      chk("coll_old", uo_out, 8'h5B);
      chk("coll_hs", uio_out, 8'hF0);
      cyc(8'h00, RR, 1'b0);
      cyc(8'h03, AR, 1'b0);
      chk("coll_new", uo_out, 8'h07);
      cyc(8'h00, RR, 1'b0);

      cyc(8'h01, AR, 1'b0);
      cyc(8'hF1, AW | WV, 1'b1);
      chk("abort_hs", uio_out, 8'h00);
      chk("abort_seg", uo_out, 8'h3F);

      for (int k = 0; k < 3000; k++) begin
         cyc(8'($urandom), 4'($urandom),
             ($urandom_range(0, 99) == 0));
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
